// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus a registered load-use stall FSM with a LOAD_LAT-cycle stall.
// Optional stall-cycle counter output is enabled by defining FWD_HAZARD_STALL_COUNT_EN.
module fwd_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_rt_used_i,
  input  logic [ADDR_W-1:0] ex_rs_i,
  input  logic [ADDR_W-1:0] ex_rt_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  input  logic [ADDR_W-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              busy_o
`ifdef FWD_HAZARD_STALL_COUNT_EN
  , output logic [CNT_W-1:0] stall_cycles_o
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("fwd_hazard_unit: LOAD_LAT must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  // The detect cycle is the first stall cycle, so STALL lasts LOAD_LAT-1 cycles.
  localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       haz;

  logic mem_a, wb_a, mem_b, wb_b;

  always_comb begin
    mem_a = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i);
    wb_a  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rs_i);
    mem_b = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == ex_rt_i);
    wb_b  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == ex_rt_i);
    fwd_a_o = mem_a ? 2'b10 : (wb_a ? 2'b01 : 2'b00);
    fwd_b_o = mem_b ? 2'b10 : (wb_b ? 2'b01 : 2'b00);
  end

  always_comb begin
    haz = ex_memread_i && (ex_rd_i != '0) &&
          ((ex_rd_i == id_rs_i) || (id_rt_used_i && (ex_rd_i == id_rt_i)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    if (state_q == IDLE) begin
      stall_o = haz;
      if (haz && (LOAD_LAT > 1) && !hold_i) begin
        state_d = STALL;
        cnt_d   = CNT_INIT;
      end
    end else begin
      stall_o = 1'b1;
      if (!hold_i) begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
    end
    flush_o = stall_o;
    busy_d  = (state_d == STALL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;

`ifdef FWD_HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Saturating: once all-ones the count sticks until reset.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_o && !hold_i && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: two instances (LOAD_LAT 1 and 3) driven by shared inputs,
// expected outputs queued per step and compared with immediate assertions.
module tb_fwd_hazard_unit;

  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i, hold_i, id_rt_used_i, ex_memread_i, mem_regwrite_i, wb_regwrite_i;
  logic [AW-1:0] id_rs_i, id_rt_i, ex_rs_i, ex_rt_i, ex_rd_i, mem_rd_i, wb_rd_i;

  logic [1:0] fwd_a1, fwd_b1, fwd_a3, fwd_b3;
  logic       stall1, flush1, busy1, stall3, flush3, busy3;
  logic [6:0] obs1, obs3;
`ifdef FWD_HAZARD_STALL_COUNT_EN
  logic [31:0] cyc1, cyc3;
`endif

  logic [6:0]  exp1_q[$];
  logic [6:0]  exp3_q[$];
  logic [31:0] cnt_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_unit #(.ADDR_W(AW), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rt_used_i(id_rt_used_i),
    .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
    .mem_rd_i(mem_rd_i), .mem_regwrite_i(mem_regwrite_i),
    .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .fwd_a_o(fwd_a1), .fwd_b_o(fwd_b1), .stall_o(stall1), .flush_o(flush1), .busy_o(busy1)
`ifdef FWD_HAZARD_STALL_COUNT_EN
    , .stall_cycles_o(cyc1)
`endif
  );

  fwd_hazard_unit #(.ADDR_W(AW), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rt_used_i(id_rt_used_i),
    .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i), .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i),
    .mem_rd_i(mem_rd_i), .mem_regwrite_i(mem_regwrite_i),
    .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .fwd_a_o(fwd_a3), .fwd_b_o(fwd_b3), .stall_o(stall3), .flush_o(flush3), .busy_o(busy3)
`ifdef FWD_HAZARD_STALL_COUNT_EN
    , .stall_cycles_o(cyc3)
`endif
  );

  // Output vector layout: {fwd_a[1:0], fwd_b[1:0], stall, flush, busy}
  assign obs1 = {fwd_a1, fwd_b1, stall1, flush1, busy1};
  assign obs3 = {fwd_a3, fwd_b3, stall3, flush3, busy3};

  task automatic clear_in();
    id_rs_i = '0; id_rt_i = '0; id_rt_used_i = 1'b0;
    ex_rs_i = '0; ex_rt_i = '0; ex_rd_i = '0; ex_memread_i = 1'b0;
    mem_rd_i = '0; mem_regwrite_i = 1'b0; wb_rd_i = '0; wb_regwrite_i = 1'b0;
  endtask

  task automatic load_haz(input logic [AW-1:0] rd);
    ex_memread_i = 1'b1; ex_rd_i = rd; id_rs_i = rd;
  endtask

  // Inputs are already applied; push expectations, let them settle, then compare.
  task automatic step(input string tag, input logic [6:0] e1, input logic [6:0] e3);
    logic [6:0] x;
    exp1_q.push_back(e1);
    exp3_q.push_back(e3);
    #2;
    x = exp1_q.pop_front();
    checks++;
    assert (obs1 === x) else begin
      errors++;
      $error("FAIL %s lat1: got %b expected %b", tag, obs1, x);
    end
    x = exp3_q.pop_front();
    checks++;
    assert (obs3 === x) else begin
      errors++;
      $error("FAIL %s lat3: got %b expected %b", tag, obs3, x);
    end
    @(negedge clk_i);
  endtask

  task automatic cnt_check(input string tag, input logic [31:0] c1, input logic [31:0] c3);
`ifdef FWD_HAZARD_STALL_COUNT_EN
    logic [31:0] x;
    cnt_q.push_back(c1);
    cnt_q.push_back(c3);
    #1;
    x = cnt_q.pop_front();
    checks++;
    assert (cyc1 === x) else begin
      errors++;
      $error("FAIL %s cnt lat1: got %0d expected %0d", tag, cyc1, x);
    end
    x = cnt_q.pop_front();
    checks++;
    assert (cyc3 === x) else begin
      errors++;
      $error("FAIL %s cnt lat3: got %0d expected %0d", tag, cyc3, x);
    end
`else
    cnt_q.delete();
    if (tag.len() < 0) $display("%0d %0d", c1, c3);
`endif
  endtask

  initial begin
    rst_i = 1'b0; hold_i = 1'b0;
    clear_in();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    cnt_check("reset", 32'd0, 32'd0);
    step("reset", 7'b0000_000, 7'b0000_000);
    rst_i = 1'b1;

    // Forwarding priority and zero-register suppression
    ex_rs_i = 5'd3; mem_rd_i = 5'd3; wb_rd_i = 5'd3; mem_regwrite_i = 1'b1; wb_regwrite_i = 1'b1;
    step("fwd_mem_wins", 7'b1000_000, 7'b1000_000);
    mem_regwrite_i = 1'b0;
    step("fwd_wb_only", 7'b0100_000, 7'b0100_000);
    mem_regwrite_i = 1'b1; ex_rt_i = 5'd3;
    step("fwd_both_mem", 7'b1010_000, 7'b1010_000);
    ex_rs_i = '0; ex_rt_i = '0; mem_rd_i = '0; wb_rd_i = '0;
    step("fwd_zero_reg", 7'b0000_000, 7'b0000_000);
    ex_rs_i = 5'd4; mem_rd_i = 5'd4; ex_rt_i = 5'd9; wb_rd_i = 5'd9;
    step("fwd_a_mem_b_wb", 7'b1001_000, 7'b1001_000);

    // rt not used by ID instruction: no hazard
    clear_in();
    ex_memread_i = 1'b1; ex_rd_i = 5'd7; id_rt_i = 5'd7; id_rs_i = 5'd1;
    step("rt_unused", 7'b0000_000, 7'b0000_000);
    id_rt_used_i = 1'b1;
    step("rt_haz_detect", 7'b0000_110, 7'b0000_110);
    clear_in();
    step("rt_haz_s2", 7'b0000_000, 7'b0000_111);
    step("rt_haz_s3", 7'b0000_000, 7'b0000_111);
    cnt_check("after_stall1", 32'd1, 32'd3);
    step("rt_haz_done", 7'b0000_000, 7'b0000_000);

    // rs hazard for one cycle; forwarding still live during STALL
    load_haz(5'd5);
    step("rs_haz_detect", 7'b0000_110, 7'b0000_110);
    clear_in();
    step("rs_haz_s2", 7'b0000_000, 7'b0000_111);
    ex_rs_i = 5'd2; mem_rd_i = 5'd2; mem_regwrite_i = 1'b1;
    step("rs_haz_s3_fwd", 7'b1000_000, 7'b1000_111);
    clear_in();
    cnt_check("after_stall2", 32'd2, 32'd6);
    step("rs_haz_done", 7'b0000_000, 7'b0000_000);

    // hold_i during STALL stretches it to 5 cycles
    load_haz(5'd5);
    step("hold_detect", 7'b0000_110, 7'b0000_110);
    clear_in(); hold_i = 1'b1;
    step("hold_c1", 7'b0000_000, 7'b0000_111);
    step("hold_c2", 7'b0000_000, 7'b0000_111);
    hold_i = 1'b0;
    cnt_check("hold_frozen", 32'd3, 32'd7);
    step("hold_s2", 7'b0000_000, 7'b0000_111);
    step("hold_s3", 7'b0000_000, 7'b0000_111);
    cnt_check("after_hold", 32'd3, 32'd9);
    step("hold_done", 7'b0000_000, 7'b0000_000);

    // hold_i in IDLE: detection still combinational, no state change
    hold_i = 1'b1; load_haz(5'd6);
    step("hold_idle_haz", 7'b0000_110, 7'b0000_110);
    hold_i = 1'b0; clear_in();
    cnt_check("hold_idle_cnt", 32'd3, 32'd9);
    step("hold_idle_after", 7'b0000_000, 7'b0000_000);

    // Persistent hazard: new stall starts in the first IDLE cycle after STALL
    load_haz(5'd8);
    step("b2b_detect", 7'b0000_110, 7'b0000_110);
    step("b2b_s2", 7'b0000_110, 7'b0000_111);
    step("b2b_s3", 7'b0000_110, 7'b0000_111);
    step("b2b_redetect", 7'b0000_110, 7'b0000_110);
    clear_in(); rst_i = 1'b0;
    step("reset_in_stall", 7'b0000_000, 7'b0000_111);
    rst_i = 1'b1;
    cnt_check("after_reset", 32'd0, 32'd0);
    step("after_reset", 7'b0000_000, 7'b0000_000);
    load_haz(5'd4);
    step("post_reset_haz", 7'b0000_110, 7'b0000_110);
    clear_in();
    step("post_reset_s2", 7'b0000_000, 7'b0000_111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding unit. Generates EX-stage operand forwarding selects (MEM over WB priority) for both source operands.
- Adds a registered load-use hazard FSM that stalls IF/ID and bubbles ID/EX for a configurable number of cycles (LOAD_LAT), so multi-cycle data memories are supported.
- Sits beside the ID/EX pipeline register. Drives the ALU operand muxes, PC write enable, IF/ID write enable and the ID/EX control flush.

Parameters:
- ADDR_W, 5: register address width.
- LOAD_LAT, 1: stall cycles per load-use hazard. Legal range 1..15.
- CNT_W, 32: stall-cycle counter width (optional feature only).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-low; one clock, synchronous active-low reset.
- hold_i  in  1  external freeze (cache miss). FSM and counters hold.
- id_rs_i  in  ADDR_W  rs address of the instruction in ID.
- id_rt_i  in  ADDR_W  rt address of the instruction in ID.
- id_rt_used_i  in  1  ID instruction reads rt.
- ex_rs_i  in  ADDR_W  rs address in EX.
- ex_rt_i  in  ADDR_W  rt address in EX.
- ex_rd_i  in  ADDR_W  destination address in EX.
- ex_memread_i  in  1  EX instruction is a load.
- mem_rd_i  in  ADDR_W  destination address in MEM.
- mem_regwrite_i  in  1  MEM instruction writes the register file.
- wb_rd_i  in  ADDR_W  destination address in WB.
- wb_regwrite_i  in  1  WB instruction writes the register file.
- fwd_a_o  out  2  rs operand select: 00 regfile, 10 MEM, 01 WB.
- fwd_b_o  out  2  rt operand select, same encoding.
- stall_o  out  1  hold PC and IF/ID.
- flush_o  out  1  zero ID/EX control (insert bubble).
- busy_o  out  1  FSM in STALL state.

Behaviour:
- Forwarding (combinational, any state):
  - fwd_a_o = 10 if mem_regwrite_i and mem_rd_i != 0 and mem_rd_i == ex_rs_i.
  - Otherwise 01 if wb_regwrite_i and wb_rd_i != 0 and wb_rd_i == ex_rs_i.
  - Otherwise 00.
  - fwd_b_o uses the same rules on ex_rt_i.
  - MEM always wins when MEM and WB match the same register. Address 0 never forwards.
- Hazard detect: haz = ex_memread_i & (ex_rd_i != 0) & ((ex_rd_i == id_rs_i) | (id_rt_used_i & ex_rd_i == id_rt_i)).
- FSM states: IDLE, STALL. 4-bit counter cnt.
- IDLE:
  - stall_o = flush_o = haz (same cycle).
  - On haz with LOAD_LAT > 1 and !hold_i: go to STALL, cnt <= LOAD_LAT-2.
  - With LOAD_LAT == 1: remain in IDLE (single-cycle stall).
- STALL:
  - stall_o = flush_o = 1; busy_o = 1; haz is ignored.
  - If !hold_i: when cnt == 0, go to IDLE; otherwise cnt <= cnt-1.
- Total stall per hazard is exactly LOAD_LAT cycles, counting the detect cycle.
- hold_i = 1 freezes state and cnt. Outputs keep following the rules for the current state, so IDLE detection is still combinational.
- Back-to-back: a hazard seen in the first IDLE cycle after STALL starts a new stall with no gap.
- Reset (rst_i == 0 at clk edge): state IDLE, cnt 0. Next cycle busy_o = 0, and stall_o/flush_o = haz. Reset mid-STALL aborts the stall.
- Reset values of the registered outputs: busy_o = 0, and stall_cycles_o = 0 when the optional feature is enabled.

Optional Feature:
- Macro: FWD_HAZARD_STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles_o [CNT_W-1:0].
  - Increments by 1 on each clock edge where stall_o = 1 and hold_i = 0 and rst_i = 1.
  - Saturates at all-ones. Cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- MEM/WB priority: mem_rd = wb_rd = ex_rs = 3, both regwrite = 1 -> fwd_a_o = 10. Clear mem_regwrite -> 01. Set all addresses to 0 -> 00.
- Load-use, LOAD_LAT = 1: ex_memread = 1, ex_rd = 5, id_rs = 5 -> stall_o = flush_o = 1 that cycle only; busy_o stays 0.
- Load-use, LOAD_LAT = 3: same hazard for one cycle then removed -> stall_o high exactly 3 cycles, busy_o high for cycles 2-3, then IDLE.
- hold_i = 1 for 2 cycles during STALL (LOAD_LAT = 3) -> stall_o high for 5 cycles total; cnt frozen.
- Reset mid-STALL: rst_i = 0 in stall cycle 2 -> busy_o = 0 next cycle; stall_o = 0 if no haz; stall_cycles_o = 0 (when enabled).
- Rt unused: ex_rd = id_rt = 7, id_rt_used = 0, id_rs = 1 -> no stall. With FWD_HAZARD_STALL_COUNT_EN, after the two-stall scenario above -> stall_cycles_o = 3+3.
